// File: rtl/serial_tx_if.sv
// Word-input handshake for serial_tx. A word transfers on a rising edge where
// valid and ready are both 1; the transmitter then drops ready until the frame ends.
interface serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] d;
  logic             valid;
  logic             ready;

  modport master (output d, output valid, input ready);
  modport slave  (input d, input valid, output ready);
endinterface

// File: rtl/serial_tx.sv
// Framed parallel-to-serial transmitter: start bit, WIDTH data bits LSB first, stop bit,
// each held DIV clocks. Define SERIAL_TX_PARITY_EN to add an even-parity bit before stop.
module serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic         c,
  input  logic         rn,
  serial_tx_if.slave   bus,
  output logic         q,
  output logic         busy,
  output logic [2:0]   state_o
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q;
  logic [DW-1:0]    div_q;
  logic [BW-1:0]    bit_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             q_q;
  logic             ready_q;
  logic             busy_q;
  logic             div_last;
`ifdef SERIAL_TX_PARITY_EN
  logic             parity_q;
`endif

  assign div_last = (div_q == DW'(DIV - 1));
  assign shreg_d  = shreg_q >> 1;

  assign q         = q_q;
  assign busy      = busy_q;
  assign bus.ready = ready_q;
  assign state_o   = state_q;

  // q, ready and busy are loaded together with the state transition that implies them.
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      q_q      <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.valid) begin
            shreg_q  <= bus.d;
            state_q  <= S_START;
            div_q    <= '0;
            bit_q    <= '0;
            q_q      <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= ^bus.d;
`endif
          end
        end
        S_START: begin
          if (div_last) begin
            div_q   <= '0;
            state_q <= S_DATA;
            q_q     <= shreg_q[0];
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        S_DATA: begin
          if (div_last) begin
            div_q   <= '0;
            shreg_q <= shreg_d;
            bit_q   <= bit_q + BW'(1);
            if (bit_q == BW'(WIDTH - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
              state_q <= S_PARITY;
              q_q     <= parity_q;
`else
              state_q <= S_STOP;
              q_q     <= 1'b1;
`endif
            end else begin
              q_q <= shreg_d[0];
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: begin
          if (div_last) begin
            div_q   <= '0;
            state_q <= S_STOP;
            q_q     <= 1'b1;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
`endif
        S_STOP: begin
          if (div_last) begin
            div_q   <= '0;
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          div_q   <= '0;
          q_q     <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: directed words, expected per-cycle line traces queued at
// acceptance and compared by an independent line monitor.
module tb_serial_tx;
  localparam int WIDTH = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int DIV = 2;
  localparam int NB  = WIDTH + 3;
`else
  localparam int DIV = 4;
  localparam int NB  = WIDTH + 2;
`endif
  localparam int FC = NB * DIV;

  logic       c  = 1'b0;
  logic       rn = 1'b0;
  logic       q;
  logic       busy;
  logic [2:0] state;

  serial_tx_if #(.WIDTH(WIDTH)) bus ();

  serial_tx #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .c       (c),
    .rn      (rn),
    .bus     (bus.slave),
    .q       (q),
    .busy    (busy),
    .state_o (state)
  );

  // clock / reset
  always #5 c = ~c;

  int cyc = 0;
  always @(posedge c) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [FC-1:0] exp_q[$];
  int            exp_t_q[$];
  int            last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [FC-1:0] expand(input logic [WIDTH-1:0] dv);
    logic [NB-1:0] fb;
    logic [FC-1:0] r;
`ifdef SERIAL_TX_PARITY_EN
    fb = {1'b1, ^dv, dv, 1'b0};
`else
    fb = {1'b1, dv, 1'b0};
`endif
    for (int k = 0; k < FC; k++) r[k] = fb[k / DIV];
    return r;
  endfunction

  // driver tasks
  task automatic wait_ready();
    int n = 0;
    @(negedge c);
    while (bus.ready !== 1'b1 && n < 200) begin
      @(negedge c);
      n++;
    end
    chk("ready_wait", bus.ready, 1);
  endtask

  task automatic send(input logic [WIDTH-1:0] dv);
    wait_ready();
    bus.d     = dv;
    bus.valid = 1'b1;
    @(posedge c);
    #1;
    last_acc = cyc;
    exp_q.push_back(expand(dv));
    exp_t_q.push_back(cyc);
    @(negedge c);
    bus.valid = 1'b0;
    bus.d     = WIDTH'($urandom_range(0, 255));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge c);
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    repeat (2) @(negedge c);
  endtask

  // scoreboard monitor
  initial begin
    logic [FC-1:0] act;
    logic [FC-1:0] expv;
    int            t_start;
    int            et;
    logic          hs_ok;
    logic          aborted;
    forever begin
      @(negedge c);
      if (rn === 1'b1 && q === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("frame_expected", 0, 1);
          repeat (FC) @(negedge c);
        end else begin
          t_start = cyc;
          act     = '0;
          hs_ok   = 1'b1;
          aborted = 1'b0;
          for (int k = 0; k < FC; k++) begin
            if (k > 0) @(negedge c);
            if (rn !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            act[k] = q;
            if (busy !== 1'b1 || bus.ready !== 1'b0) hs_ok = 1'b0;
          end
          expv = exp_q.pop_front();
          et   = exp_t_q.pop_front();
          if (!aborted) begin
            chk("frame_bits", act, expv);
            chk("frame_start_cycle", t_start, et);
            chk("busy_ready_in_frame", hs_ok, 1);
            @(negedge c);
            chk("idle_after_frame", {q, bus.ready, busy}, 3'b110);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] vecs [4];
    int t0;
    int target;
    vecs = '{8'hA5, 8'h07, 8'hFF, 8'h00};
    bus.valid = 1'b0;
    bus.d     = '0;

    // reset held with clock running
    repeat (4) begin
      @(negedge c);
      chk("reset_outputs", {q, bus.ready, busy}, 3'b110);
      chk("reset_state", state, 0);
    end
    @(negedge c);
    rn = 1'b1;
    repeat (3) begin
      @(negedge c);
      chk("idle_after_release", {q, bus.ready, busy}, 3'b110);
    end

    // single frames
    foreach (vecs[i]) begin
      send(vecs[i]);
      drain();
    end

    // valid while busy is ignored
    send(8'h3C);
    repeat (10) @(negedge c);
    chk("ready_low_midframe", bus.ready, 0);
    bus.d     = 8'hFF;
    bus.valid = 1'b1;
    @(negedge c);
    bus.valid = 1'b0;
    drain();
    repeat (FC) @(negedge c);
    chk("no_second_frame", {q, bus.ready, busy}, 3'b110);

    // back-to-back with valid held
    wait_ready();
    bus.d     = 8'h01;
    bus.valid = 1'b1;
    @(posedge c);
    #1;
    t0 = cyc;
    exp_q.push_back(expand(8'h01));
    exp_t_q.push_back(t0);
    exp_q.push_back(expand(8'h80));
    exp_t_q.push_back(t0 + FC + 1);
    @(negedge c);
    bus.d = 8'h80;
    repeat (FC + 1) @(posedge c);
    @(negedge c);
    bus.valid = 1'b0;
    drain();

    // reset during data bit 3
    send(8'h00);
    target = last_acc + 4 * DIV;
    while (cyc < target) begin
      @(posedge c);
      #1;
    end
    #1;
    chk("q_low_before_reset", q, 0);
    rn = 1'b0;
    #1;
    chk("reset_midframe_q", q, 1);
    chk("reset_midframe_hs", {bus.ready, busy}, 2'b10);
    chk("reset_midframe_state", state, 0);
    repeat (3) @(negedge c);
    chk("reset_hold_q", q, 1);
    rn = 1'b1;
    repeat (2) @(negedge c);
    chk("ready_after_reset", bus.ready, 1);
    chk("queue_cleared_by_abort", exp_q.size(), 0);
    send(8'hF0);
    drain();

    repeat (FC) @(negedge c);
    chk("final_idle", {q, bus.ready, busy}, 3'b110);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
